// File: rtl/gray_sobel_pkg.sv
// Shared mode/state types, default widths and mode helpers for the gray/Sobel router.
package gray_sobel_pkg;

  localparam int DEF_PIXEL_W      = 24;
  localparam int DEF_GRAY_W       = 8;
  localparam int DEF_FRAME_PIXELS = 307200;
  localparam int DEF_GRAY_LAT     = 2;
  localparam int DEF_BYPASS_LAT   = 2;
  localparam int DEF_DRAIN_CYCLES = 16;

  typedef enum logic [1:0] {
    MODE_GRAY   = 2'b00,
    MODE_SOBEL  = 2'b01,
    MODE_CHAIN  = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  function automatic logic uses_gray(input mode_t m);
    return (m == MODE_GRAY) || (m == MODE_CHAIN);
  endfunction

  function automatic logic uses_sobel(input mode_t m);
    return (m == MODE_SOBEL) || (m == MODE_CHAIN);
  endfunction

endpackage

// File: rtl/gray_sobel_router_valid_delay_line.sv
// Fixed-depth shift register carrying a valid bit and its data; data is zeroed when not valid.
module valid_delay_line
  import gray_sobel_pkg::*;
#(
  parameter int WIDTH = DEF_PIXEL_W,
  parameter int DEPTH = DEF_BYPASS_LAT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    valid_d[0] = valid_i;
    data_d[0]  = valid_i ? data_i : '0;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/gray_sobel_router.sv
// Frame-level router: latches the mode at frame start, sequences the gray/Sobel engines
// and delivers one registered, latency-aligned output stream for every mode.
module gray_sobel_router
  import gray_sobel_pkg::*;
#(
  parameter int PIXEL_W      = DEF_PIXEL_W,
  parameter int GRAY_W       = DEF_GRAY_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int GRAY_LAT     = DEF_GRAY_LAT,
  parameter int BYPASS_LAT   = DEF_BYPASS_LAT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  localparam int CNT_W       = $clog2(FRAME_PIXELS + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         select_i,
  input  logic               start_i,
  input  logic               finish_i,
  input  logic               in_valid_i,
  input  logic [PIXEL_W-1:0] in_pixel_i,
  output logic               gray_start_o,
  output logic               gray_finish_o,
  output logic [PIXEL_W-1:0] gray_px_o,
  input  logic [GRAY_W-1:0]  gray_px_i,
  output logic               sobel_start_o,
  output logic               sobel_finish_o,
  output logic [GRAY_W-1:0]  sobel_px_o,
  input  logic [GRAY_W-1:0]  sobel_px_i,
  input  logic               sobel_valid_i,
  output logic [PIXEL_W-1:0] out_pixel_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         mode_o,
  output logic [CNT_W-1:0]   px_count_o,
  output logic               mode_err_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [CNT_W-1:0]     px_count_q, px_count_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 mode_err_q, mode_err_d;
  logic                 done_q, done_d;
  logic                 gray_finish_q, gray_finish_d;
  logic                 sobel_finish_q, sobel_finish_d;
  logic                 out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0]   out_pixel_q, out_pixel_d;

  logic                 accept;
  logic                 finish_pulse;
  logic                 busy;
  logic                 gray_dl_valid;
  logic [0:0]           gray_dl_tag;
  logic                 byp_dl_valid;
  logic [PIXEL_W-1:0]   byp_dl_data;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    px_count_d   = px_count_q;
    drain_cnt_d  = drain_cnt_q;
    mode_err_d   = mode_err_q;
    done_d       = 1'b0;
    accept       = 1'b0;
    finish_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !finish_i) begin
          state_d     = RUN;
          mode_d      = mode_t'(select_i);
          px_count_d  = '0;
          drain_cnt_d = '0;
          mode_err_d  = 1'b0;
        end
      end
      RUN: begin
        if (mode_t'(select_i) != mode_q) begin
          mode_err_d = 1'b1;
        end
        if (finish_i) begin
          state_d      = IDLE;
          finish_pulse = 1'b1;
        end else if (in_valid_i) begin
          accept = 1'b1;
          if (px_count_q != CNT_W'(FRAME_PIXELS)) begin
            px_count_d = px_count_q + CNT_W'(1);
          end
          if (px_count_q == CNT_W'(FRAME_PIXELS - 1)) begin
            state_d      = DRAIN;
            drain_cnt_d  = '0;
            finish_pulse = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (finish_i) begin
          state_d      = IDLE;
          finish_pulse = 1'b1;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gray_finish_d  = finish_pulse && uses_gray(mode_q);
    sobel_finish_d = finish_pulse && uses_sobel(mode_q);
  end

  // Gray beats are tagged with whether they were accepted in pure gray mode, so beats
  // still in flight when a new frame changes the mode are not mis-routed.
  valid_delay_line #(
    .WIDTH (1),
    .DEPTH (GRAY_LAT)
  ) u_gray_dl (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (accept),
    .data_i  (mode_q == MODE_GRAY),
    .valid_o (gray_dl_valid),
    .data_o  (gray_dl_tag)
  );

  valid_delay_line #(
    .WIDTH (PIXEL_W),
    .DEPTH (BYPASS_LAT)
  ) u_bypass_dl (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (accept && (mode_q == MODE_BYPASS)),
    .data_i  (in_pixel_i),
    .valid_o (byp_dl_valid),
    .data_o  (byp_dl_data)
  );

  always_comb begin
    out_valid_d = 1'b0;
    out_pixel_d = '0;
    case (mode_q)
      MODE_GRAY: begin
        out_valid_d = gray_dl_valid && gray_dl_tag[0];
        out_pixel_d = PIXEL_W'(gray_px_i);
      end
      MODE_SOBEL, MODE_CHAIN: begin
        out_valid_d = sobel_valid_i && busy;
        out_pixel_d = PIXEL_W'(sobel_px_i);
      end
      MODE_BYPASS: begin
        out_valid_d = byp_dl_valid;
        out_pixel_d = byp_dl_data;
      end
      default: ;
    endcase
    if (!out_valid_d) begin
      out_pixel_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      mode_q         <= MODE_GRAY;
      px_count_q     <= '0;
      drain_cnt_q    <= '0;
      mode_err_q     <= 1'b0;
      done_q         <= 1'b0;
      gray_finish_q  <= 1'b0;
      sobel_finish_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_pixel_q    <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      px_count_q     <= px_count_d;
      drain_cnt_q    <= drain_cnt_d;
      mode_err_q     <= mode_err_d;
      done_q         <= done_d;
      gray_finish_q  <= gray_finish_d;
      sobel_finish_q <= sobel_finish_d;
      out_valid_q    <= out_valid_d;
      out_pixel_q    <= out_pixel_d;
    end
  end

  // Engine feeds are gated off in IDLE so nothing leaks to the cores between frames.
  always_comb begin
    gray_px_o  = '0;
    sobel_px_o = '0;
    if (busy) begin
      if (uses_gray(mode_q)) begin
        gray_px_o = in_pixel_i;
      end
      if (mode_q == MODE_SOBEL) begin
        sobel_px_o = in_pixel_i[GRAY_W-1:0];
      end else if (mode_q == MODE_CHAIN) begin
        sobel_px_o = gray_px_i;
      end
    end
  end

  assign gray_start_o   = busy && uses_gray(mode_q);
  assign sobel_start_o  = busy && uses_sobel(mode_q);
  assign gray_finish_o  = gray_finish_q;
  assign sobel_finish_o = sobel_finish_q;
  assign out_pixel_o    = out_pixel_q;
  assign out_valid_o    = out_valid_q;
  assign busy_o         = busy;
  assign done_o         = done_q;
  assign mode_o         = mode_q;
  assign px_count_o     = px_count_q;
  assign mode_err_o     = mode_err_q;

endmodule
